// File: rtl/exec_seq_if.sv
// ============================================================================
// Module   : exec_seq_if
// Brief    : Fetch/LSU/datapath handshake bundle for the exec_seq sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface exec_seq_if;
    logic        ifu_req;
    logic        ifu_valid;
    logic [31:0] inst;
    logic [31:0] ir;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_valid;
    logic        dec_regwr;
    logic        rf_we;
    logic        pc_we;
    logic [2:0]  state;
    logic [63:0] instret;
    logic        halt;
    logic        err;

    // Sequencer side
    modport slave (
        output ifu_req, ir, lsu_req, lsu_wen, rf_we, pc_we, state, instret, halt, err,
        input  ifu_valid, inst, lsu_valid, dec_regwr
    );

    // Memory/datapath side
    modport master (
        input  ifu_req, ir, lsu_req, lsu_wen, rf_we, pc_we, state, instret, halt, err,
        output ifu_valid, inst, lsu_valid, dec_regwr
    );
endinterface

`default_nettype wire

// File: rtl/exec_seq.sv
// ============================================================================
// Module   : exec_seq
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire
//            counter, wait watchdog and sticky halt/error reporting.
//            Optional: EXEC_SEQ_EBREAK_HALT_EN makes ebreak halt the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exec_seq #(
    parameter int TIMEOUT = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    exec_seq_if.slave   bus
);

    localparam int              c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TO    = c_CNT_W'(TIMEOUT);
    localparam logic [6:0]      c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]      c_OP_STORE = 7'b0100011;
`ifdef EXEC_SEQ_EBREAK_HALT_EN
    localparam logic [31:0]     c_EBREAK   = 32'h0010_0073;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_ir;
    logic [63:0]          r_instret;
    logic                 r_halt;
    logic                 r_err;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_load_ir;
    logic                 w_retire;
    logic                 w_halt_set;
    logic                 w_timeout;
    logic                 w_is_store;
    logic                 w_is_mem;

    assign w_is_store = (r_ir[6:0] == c_OP_STORE);
    assign w_is_mem   = (r_ir[6:0] == c_OP_LOAD) || w_is_store;
    // Saturating increment: the watchdog counter must never wrap
    assign w_cnt_inc  = (r_cnt == c_TO) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_instret <= '0;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_load_ir) begin
                r_ir <= bus.inst;
            end
            if (w_retire) begin
                r_instret <= r_instret + 64'd1;
            end
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_load_ir   = 1'b0;
        w_retire    = 1'b0;
        w_halt_set  = 1'b0;
        w_timeout   = 1'b0;
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_wen = 1'b0;
        bus.rf_we   = 1'b0;
        bus.pc_we   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next     = S_FETCH;
                w_cnt_next = '0;
            end
            S_FETCH: begin
                bus.ifu_req = 1'b1;
                // A valid in the same cycle the count expires still wins
                if (bus.ifu_valid) begin
                    w_next    = S_DECODE;
                    w_load_ir = 1'b1;
                end else if (w_cnt_inc == c_TO) begin
                    w_next     = S_HALT;
                    w_halt_set = 1'b1;
                    w_timeout  = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_cnt_next = '0;
`ifdef EXEC_SEQ_EBREAK_HALT_EN
                if (r_ir == c_EBREAK) begin
                    w_next     = S_HALT;
                    w_halt_set = 1'b1;
                end else
`endif
                if (w_is_mem) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                bus.lsu_req = 1'b1;
                bus.lsu_wen = w_is_store;
                if (bus.lsu_valid) begin
                    w_next = S_WB;
                end else if (w_cnt_inc == c_TO) begin
                    w_next     = S_HALT;
                    w_halt_set = 1'b1;
                    w_timeout  = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_WB: begin
                bus.rf_we  = bus.dec_regwr;
                bus.pc_we  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
                w_cnt_next = '0;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.ir      = r_ir;
    assign bus.state   = r_state;
    assign bus.instret = r_instret;
    assign bus.halt    = r_halt;
    assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_exec_seq.sv
// ============================================================================
// Module   : tb_exec_seq
// Brief    : Scoreboard bench for exec_seq (TIMEOUT=4): directed instructions,
//            watchdog boundaries, ebreak handling and mid-operation reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exec_seq;

    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_FETCH = 3'd1;
    localparam logic [2:0]  ST_HALT  = 3'd6;
    localparam logic [31:0] I_ADDI   = 32'h0010_0093;
    localparam logic [31:0] I_LOAD   = 32'h0000_a103;
    localparam logic [31:0] I_STORE  = 32'h0020_a023;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;

    typedef struct {
        logic [31:0]     ins;
        logic            rw;
        logic            wen;
        int              mem_cyc;
        longint unsigned ret;
        int              wb_cyc;
    } exp_t;

    logic clk;
    logic rst;
    exec_seq_if bus();

    exec_seq #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t            sb[$];
    exp_t            mon_e;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              mem_cnt  = 0;
    longint unsigned exp_ret  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected DUT event at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ifu_valid = 1'b0;
        bus.inst      = '0;
        bus.lsu_valid = 1'b0;
        bus.dec_regwr = 1'b0;
        sb.delete();
        exp_ret = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (bus.state !== ST_FETCH && n < 20) begin
            tick();
            n++;
        end
        chk("reach_fetch", 64'(bus.state), 64'(ST_FETCH));
    endtask

    // fw fetch wait cycles, mw memory wait cycles; expectations are per-vector
    task automatic do_inst(input logic [31:0] ins, input int fw, input int mw,
                           input logic rw, input logic is_mem, input logic wen);
        exp_t e;
        wait_fetch();
        e.ins     = ins;
        e.rw      = rw;
        e.wen     = wen;
        e.mem_cyc = is_mem ? mw + 1 : 0;
        e.ret     = exp_ret;
        e.wb_cyc  = cyc + fw + 3 + e.mem_cyc;
        sb.push_back(e);
        exp_ret++;
        bus.dec_regwr = rw;
        for (int i = 0; i < fw; i++) begin
            bus.ifu_valid = 1'b0;
            tick();
        end
        bus.ifu_valid = 1'b1;
        bus.inst      = ins;
        tick();
        bus.inst = 32'hFFFF_FFFF;
        tick();
        bus.ifu_valid = 1'b0;
        bus.inst      = '0;
        tick();
        if (is_mem) begin
            for (int i = 0; i < mw; i++) begin
                bus.lsu_valid = 1'b0;
                tick();
            end
            bus.lsu_valid = 1'b1;
            tick();
            bus.lsu_valid = 1'b0;
        end
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (bus.rf_we && !bus.pc_we) fail_now("rf_we_outside_wb");
            if (bus.lsu_req) begin
                mem_cnt++;
                if (sb.size() == 0) fail_now("lsu_req_unexpected");
                else chk("lsu_wen", 64'(bus.lsu_wen), 64'(sb[0].wen));
            end
            if (bus.pc_we) begin
                if (sb.size() == 0) begin
                    fail_now("retire_unexpected");
                end else begin
                    mon_e = sb.pop_front();
                    chk("wb_rf_we", 64'(bus.rf_we), 64'(mon_e.rw));
                    chk("wb_ir", 64'(bus.ir), 64'(mon_e.ins));
                    chk("wb_instret", bus.instret, mon_e.ret);
                    chk("wb_cycle", 64'(cyc), 64'(mon_e.wb_cyc));
                    chk("mem_cycles", 64'(mem_cnt), 64'(mon_e.mem_cyc));
                end
                mem_cnt = 0;
            end
        end
    end

    initial begin
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_state", 64'(bus.state), 64'(ST_IDLE));
        chk("rst_ir", 64'(bus.ir), 64'h0);
        chk("rst_instret", bus.instret, 64'h0);
        chk("rst_halt", 64'(bus.halt), 64'h0);
        chk("rst_err", 64'(bus.err), 64'h0);
        chk("rst_strobes", 64'({bus.ifu_req, bus.lsu_req, bus.rf_we, bus.pc_we}), 64'h0);
        rst = 1'b0;
        chk("idle_after_rst", 64'(bus.state), 64'(ST_IDLE));
        tick();
        chk("first_fetch", 64'(bus.state), 64'(ST_FETCH));
        chk("first_ifu_req", 64'(bus.ifu_req), 64'h1);

        do_inst(I_ADDI, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("instret_after_addi", bus.instret, 64'd1);
        do_inst(I_LOAD, 1, 3, 1'b1, 1'b1, 1'b0);
        do_inst(I_STORE, 0, 0, 1'b0, 1'b1, 1'b1);
        do_inst(I_ADDI, 3, 0, 1'b1, 1'b0, 1'b0);
        chk("no_err_valid_at_limit", 64'({bus.halt, bus.err}), 64'h0);
        chk("instret_after_four", bus.instret, 64'd4);

`ifdef EXEC_SEQ_EBREAK_HALT_EN
        wait_fetch();
        bus.ifu_valid = 1'b1;
        bus.inst      = I_EBREAK;
        tick();
        bus.ifu_valid = 1'b0;
        tick();
        tick();
        chk("ebreak_state", 64'(bus.state), 64'(ST_HALT));
        chk("ebreak_halt", 64'(bus.halt), 64'h1);
        chk("ebreak_err", 64'(bus.err), 64'h0);
        chk("ebreak_instret", bus.instret, exp_ret);
        tick();
        tick();
        chk("ebreak_stays_halt", 64'(bus.state), 64'(ST_HALT));
`else
        do_inst(I_EBREAK, 0, 0, 1'b0, 1'b0, 1'b0);
        do_inst(I_ADDI, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("ebreak_no_halt", 64'(bus.halt), 64'h0);
        chk("ebreak_instret", bus.instret, exp_ret);
`endif

        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("timeout_wait_fetch", 64'(bus.state), 64'(ST_FETCH));
            bus.ifu_valid = 1'b0;
            tick();
        end
        chk("timeout_state", 64'(bus.state), 64'(ST_HALT));
        chk("timeout_halt", 64'(bus.halt), 64'h1);
        chk("timeout_err", 64'(bus.err), 64'h1);
        chk("timeout_ifu_req", 64'(bus.ifu_req), 64'h0);
        bus.ifu_valid = 1'b1;
        tick();
        bus.ifu_valid = 1'b0;
        chk("halt_sticky", 64'(bus.state), 64'(ST_HALT));

        do_reset();
        do_inst(I_ADDI, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_fetch();
        mon_e.ins = I_LOAD; mon_e.rw = 1'b1; mon_e.wen = 1'b0;
        mon_e.mem_cyc = 1; mon_e.ret = exp_ret; mon_e.wb_cyc = 0;
        sb.push_back(mon_e);
        bus.ifu_valid = 1'b1;
        bus.inst      = I_LOAD;
        tick();
        bus.ifu_valid = 1'b0;
        tick();
        tick();
        chk("mem_lsu_req", 64'(bus.lsu_req), 64'h1);
        rst = 1'b1;
        sb.delete();
        exp_ret = 0;
        tick();
        chk("midrst_state", 64'(bus.state), 64'(ST_IDLE));
        chk("midrst_lsu_req", 64'(bus.lsu_req), 64'h0);
        chk("midrst_instret", bus.instret, 64'h0);
        rst = 1'b0;
        do_inst(I_ADDI, 0, 0, 1'b1, 1'b0, 1'b0);

        tick();
        tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
